// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave register file.
//   N_RW read/write control registers (byte-strobed, per-register write pulse)
//   and N_RO read-only status registers (per-register read pulse).
//   One outstanding transaction per direction; read and write paths are independent.
// Optional build macro: AXI_REGFILE_PROT_CHECK_EN
//   When defined, any access with a non-zero AxPROT completes with SLVERR and
//   has no register effect and no pulse. When undefined, AxPROT is ignored.
module axi_lite_regfile #(
   parameter int unsigned        DATA_W     = 32,
   parameter int unsigned        ADDR_W     = 16,
   parameter int unsigned        N_RW       = 8,
   parameter int unsigned        N_RO       = 8,
   parameter int unsigned        RO_BASE    = 64,
   parameter logic [DATA_W-1:0]  RW_RST_VAL = '0
) (
   input  logic                    axi_clk,
   input  logic                    axi_rst,
   input  logic [ADDR_W-1:0]       axi_awaddr,
   input  logic [2:0]              axi_awprot,
   input  logic                    axi_awvalid,
   output logic                    axi_awready,
   input  logic [DATA_W-1:0]       axi_wdata,
   input  logic [DATA_W/8-1:0]     axi_wstrb,
   input  logic                    axi_wvalid,
   output logic                    axi_wready,
   output logic [1:0]              axi_bresp,
   output logic                    axi_bvalid,
   input  logic                    axi_bready,
   input  logic [ADDR_W-1:0]       axi_araddr,
   input  logic [2:0]              axi_arprot,
   input  logic                    axi_arvalid,
   output logic                    axi_arready,
   output logic [DATA_W-1:0]       axi_rdata,
   output logic [1:0]              axi_rresp,
   output logic                    axi_rvalid,
   input  logic                    axi_rready,
   output logic [N_RW*DATA_W-1:0]  user_rw_data,
   output logic [N_RW-1:0]         user_wr_pulse,
   input  logic [N_RO*DATA_W-1:0]  user_ro_data,
   output logic [N_RO-1:0]         user_rd_pulse
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_W - LSB;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      WR_INIT,   // leaving reset, no readies yet
      WR_IDLE,   // waiting for AW and W
      WR_ADDR,   // address held, waiting for data
      WR_DATA,   // data held, waiting for address
      WR_BOTH,   // both held, commit on next edge
      WR_RESP    // response pending
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_INIT,
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic                    aw_rdy, w_rdy, b_vld;
   logic                    ar_rdy, r_vld;
   logic                    aw_hs, w_hs, ar_hs;
   logic                    wr_commit;

   logic [IDX_W-1:0]        aw_idx_q;
   logic                    aw_prot_ok_q;
   logic [DATA_W-1:0]       w_data_q;
   logic [STRB_W-1:0]       w_strb_q;
   logic [1:0]              bresp_q;
   logic [N_RW-1:0]         wr_pulse_q;

   logic [DATA_W-1:0]       rw_regs [N_RW];

   logic [IDX_W-1:0]        ar_idx;
   logic [DATA_W-1:0]       rd_data_c;
   logic                    rd_ok_c;
   logic [N_RO-1:0]         rd_ro_sel_c;
   logic                    wr_hit_c;

   logic [DATA_W-1:0]       rdata_q;
   logic [1:0]              rresp_q;
   logic [N_RO-1:0]         rd_pulse_q;

   logic                    aw_prot_ok_c;
   logic                    ar_prot_ok_c;
   logic                    unused_bits;

`ifdef AXI_REGFILE_PROT_CHECK_EN
   assign aw_prot_ok_c = (axi_awprot == 3'b000);
   assign ar_prot_ok_c = (axi_arprot == 3'b000);
   assign unused_bits  = ^{axi_awaddr[LSB-1:0], axi_araddr[LSB-1:0]};
`else
   assign aw_prot_ok_c = 1'b1;
   assign ar_prot_ok_c = 1'b1;
   assign unused_bits  = ^{axi_awprot, axi_arprot,
                           axi_awaddr[LSB-1:0], axi_araddr[LSB-1:0]};
`endif

   assign aw_hs     = axi_awvalid && aw_rdy;
   assign w_hs      = axi_wvalid && w_rdy;
   assign ar_hs     = axi_arvalid && ar_rdy;
   assign wr_commit = (wr_state == WR_BOTH);
   assign ar_idx    = axi_araddr[ADDR_W-1:LSB];

   assign axi_awready   = aw_rdy;
   assign axi_wready    = w_rdy;
   assign axi_bvalid    = b_vld;
   assign axi_bresp     = bresp_q;
   assign axi_arready   = ar_rdy;
   assign axi_rvalid    = r_vld;
   assign axi_rdata     = rdata_q;
   assign axi_rresp     = rresp_q;
   assign user_wr_pulse = wr_pulse_q;
   assign user_rd_pulse = rd_pulse_q;

   // Write channel state register
   always_ff @(posedge axi_clk) begin
      if (axi_rst) wr_state <= WR_INIT;
      else         wr_state <= wr_next;
   end

   // Write channel next state and handshake outputs
   always_comb begin
      wr_next = wr_state;
      aw_rdy  = 1'b0;
      w_rdy   = 1'b0;
      b_vld   = 1'b0;
      case (wr_state)
         WR_INIT: wr_next = WR_IDLE;
         WR_IDLE: begin
            aw_rdy = 1'b1;
            w_rdy  = 1'b1;
            if (axi_awvalid && axi_wvalid) wr_next = WR_BOTH;
            else if (axi_awvalid)          wr_next = WR_ADDR;
            else if (axi_wvalid)           wr_next = WR_DATA;
         end
         WR_ADDR: begin
            w_rdy = 1'b1;
            if (axi_wvalid) wr_next = WR_BOTH;
         end
         WR_DATA: begin
            aw_rdy = 1'b1;
            if (axi_awvalid) wr_next = WR_BOTH;
         end
         WR_BOTH: wr_next = WR_RESP;
         WR_RESP: begin
            b_vld = 1'b1;
            if (axi_bready) wr_next = WR_IDLE;
         end
         default: wr_next = WR_INIT;
      endcase
   end

   // Hold the write address and data independently as each handshake completes
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         aw_idx_q     <= '0;
         aw_prot_ok_q <= 1'b0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
      end else begin
         if (aw_hs) begin
            aw_idx_q     <= axi_awaddr[ADDR_W-1:LSB];
            aw_prot_ok_q <= aw_prot_ok_c;
         end
         if (w_hs) begin
            w_data_q <= axi_wdata;
            w_strb_q <= axi_wstrb;
         end
      end
   end

   // Write decode: only an RW hit with acceptable protection takes effect
   always_comb begin
      wr_hit_c = 1'b0;
      for (int unsigned i = 0; i < N_RW; i++) begin
         if (32'(aw_idx_q) == i) wr_hit_c = aw_prot_ok_q;
      end
   end

   // Write response code, latched at commit
   always_ff @(posedge axi_clk) begin
      if (axi_rst)        bresp_q <= '0;
      else if (wr_commit) bresp_q <= wr_hit_c ? RESP_OKAY : RESP_SLVERR;
   end

   // RW register bank: byte-strobed update and one-cycle write pulse at commit
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         for (int unsigned i = 0; i < N_RW; i++) rw_regs[i] <= RW_RST_VAL;
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= '0;
         if (wr_commit && wr_hit_c) begin
            for (int unsigned i = 0; i < N_RW; i++) begin
               if (32'(aw_idx_q) == i) begin
                  for (int unsigned b = 0; b < STRB_W; b++) begin
                     if (w_strb_q[b]) rw_regs[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                  end
                  wr_pulse_q[i] <= |w_strb_q;
               end
            end
         end
      end
   end

   // Flatten the RW bank onto the user-side bus
   always_comb begin
      user_rw_data = '0;
      for (int unsigned i = 0; i < N_RW; i++) begin
         user_rw_data[i*DATA_W +: DATA_W] = rw_regs[i];
      end
   end

   // Read channel state register
   always_ff @(posedge axi_clk) begin
      if (axi_rst) rd_state <= RD_INIT;
      else         rd_state <= rd_next;
   end

   // Read channel next state and handshake outputs
   always_comb begin
      rd_next = rd_state;
      ar_rdy  = 1'b0;
      r_vld   = 1'b0;
      case (rd_state)
         RD_INIT: rd_next = RD_IDLE;
         RD_IDLE: begin
            ar_rdy = 1'b1;
            if (axi_arvalid) rd_next = RD_RESP;
         end
         RD_RESP: begin
            r_vld = 1'b1;
            if (axi_rready) rd_next = RD_IDLE;
         end
         default: rd_next = RD_INIT;
      endcase
   end

   // Read decode and data mux; RW values are pre-commit when sampled on a commit edge
   always_comb begin
      rd_data_c   = '0;
      rd_ok_c     = 1'b0;
      rd_ro_sel_c = '0;
      if (ar_prot_ok_c) begin
         for (int unsigned i = 0; i < N_RW; i++) begin
            if (32'(ar_idx) == i) begin
               rd_data_c = rw_regs[i];
               rd_ok_c   = 1'b1;
            end
         end
         for (int unsigned j = 0; j < N_RO; j++) begin
            if (32'(ar_idx) == RO_BASE + j) begin
               rd_data_c      = user_ro_data[j*DATA_W +: DATA_W];
               rd_ok_c        = 1'b1;
               rd_ro_sel_c[j] = 1'b1;
            end
         end
      end
   end

   // Capture read data/response on the AR handshake and pulse the RO register read
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         rdata_q    <= '0;
         rresp_q    <= '0;
         rd_pulse_q <= '0;
      end else begin
         rd_pulse_q <= '0;
         if (ar_hs) begin
            rdata_q    <= rd_data_c;
            rresp_q    <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            rd_pulse_q <= rd_ro_sel_c;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Testbench for axi_lite_regfile: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi_lite_regfile;

   localparam int unsigned NRW  = 8;
   localparam int unsigned NRO  = 8;
   localparam int unsigned ROB  = 64;

   logic          axi_clk = 1'b0;
   logic          axi_rst;
   logic [15:0]   axi_awaddr;
   logic [2:0]    axi_awprot;
   logic          axi_awvalid;
   logic          axi_awready;
   logic [31:0]   axi_wdata;
   logic [3:0]    axi_wstrb;
   logic          axi_wvalid;
   logic          axi_wready;
   logic [1:0]    axi_bresp;
   logic          axi_bvalid;
   logic          axi_bready;
   logic [15:0]   axi_araddr;
   logic [2:0]    axi_arprot;
   logic          axi_arvalid;
   logic          axi_arready;
   logic [31:0]   axi_rdata;
   logic [1:0]    axi_rresp;
   logic          axi_rvalid;
   logic          axi_rready;
   logic [255:0]  user_rw_data;
   logic [7:0]    user_wr_pulse;
   logic [255:0]  user_ro_data;
   logic [7:0]    user_rd_pulse;

   axi_lite_regfile #(
      .DATA_W(32), .ADDR_W(16), .N_RW(NRW), .N_RO(NRO), .RO_BASE(ROB), .RW_RST_VAL(32'h0)
   ) dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst),
      .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
      .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
      .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready),
      .user_rw_data(user_rw_data), .user_wr_pulse(user_wr_pulse),
      .user_ro_data(user_ro_data), .user_rd_pulse(user_rd_pulse)
   );

   always #5 axi_clk = ~axi_clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_rw [NRW];
   logic [31:0] m_ro [NRO];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [255:0] rw_vec();
      logic [255:0] v;
      for (int i = 0; i < NRW; i++) v[i*32 +: 32] = m_rw[i];
      return v;
   endfunction

   task automatic drive_ro();
      for (int j = 0; j < NRO; j++) user_ro_data[j*32 +: 32] = m_ro[j];
   endtask

   // Full write transaction; called and returns at a negedge.
   task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat,
                            output logic [7:0] pulse_c, output int n_pulse,
                            output bit ready_leak, output bit ready_after);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, b_hs, seen = 0, got_b = 0;
      int cyc = 0, wait_b = 0;
      resp = 2'b11; lat = 0; pulse_c = '0; n_pulse = 0; ready_leak = 0; ready_after = 0;
      axi_awaddr = addr; axi_awprot = prot; axi_wdata = data; axi_wstrb = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         axi_awvalid = !aw_done && cyc >= aw_dly;
         axi_wvalid  = !w_done && cyc >= w_dly;
         if (aw_done && axi_awready) ready_leak = 1;
         if (w_done && axi_wready)   ready_leak = 1;
         if (user_wr_pulse != '0) n_pulse++;
         aw_hs = axi_awvalid && axi_awready;
         w_hs  = axi_wvalid && axi_wready;
         @(posedge axi_clk); @(negedge axi_clk);
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done = 1;
         cyc++;
      end
      axi_awvalid = 0; axi_wvalid = 0;
      if (!(aw_done && w_done)) begin
         check("wr_addr_data_timeout", 0, 1);
         return;
      end
      cyc = 0;
      while (!got_b && cyc < 40) begin
         if (axi_awready || axi_wready) ready_leak = 1;
         if (user_wr_pulse != '0) n_pulse++;
         if (axi_bvalid) begin
            if (!seen) begin
               seen = 1; lat = cyc; pulse_c = user_wr_pulse; resp = axi_bresp;
            end
            axi_bready = (wait_b >= b_dly);
            wait_b++;
         end
         b_hs = axi_bvalid && axi_bready;
         @(posedge axi_clk); @(negedge axi_clk);
         got_b = b_hs;
         cyc++;
      end
      axi_bready = 0;
      if (!got_b) begin
         check("wr_bresp_timeout", 0, 1);
         return;
      end
      if (user_wr_pulse != '0) n_pulse++;
      ready_after = axi_awready && axi_wready;
   endtask

   // Full read transaction; RO inputs are inverted while rvalid is held to
   // prove the data was captured at the address handshake.
   task automatic axi_read(input logic [15:0] addr, input logic [2:0] prot,
                           input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [31:0] data_end,
                           output logic [1:0] resp, output int lat,
                           output logic [7:0] pulse_r, output int n_pulse,
                           output bit ready_leak);
      bit ar_done = 0, ar_hs, r_hs, seen = 0, got_r = 0;
      int cyc = 0, wait_r = 0;
      logic [255:0] ro_saved;
      data = '0; data_end = '0; resp = 2'b11; lat = 0; pulse_r = '0; n_pulse = 0; ready_leak = 0;
      axi_araddr = addr; axi_arprot = prot;
      while (!ar_done && cyc < 40) begin
         axi_arvalid = cyc >= ar_dly;
         if (user_rd_pulse != '0) n_pulse++;
         ar_hs = axi_arvalid && axi_arready;
         @(posedge axi_clk); @(negedge axi_clk);
         ar_done = ar_hs;
         cyc++;
      end
      axi_arvalid = 0;
      if (!ar_done) begin
         check("rd_addr_timeout", 0, 1);
         return;
      end
      ro_saved = user_ro_data;
      cyc = 0;
      while (!got_r && cyc < 40) begin
         if (axi_arready) ready_leak = 1;
         if (user_rd_pulse != '0) n_pulse++;
         if (axi_rvalid) begin
            if (!seen) begin
               seen = 1; lat = cyc + 1; pulse_r = user_rd_pulse;
               data = axi_rdata; resp = axi_rresp;
               user_ro_data = ~ro_saved;
            end
            axi_rready = (wait_r >= r_dly);
            wait_r++;
         end
         r_hs = axi_rvalid && axi_rready;
         if (r_hs) data_end = axi_rdata;
         @(posedge axi_clk); @(negedge axi_clk);
         got_r = r_hs;
         cyc++;
      end
      axi_rready = 0;
      user_ro_data = ro_saved;
      if (!got_r) begin
         check("rd_data_timeout", 0, 1);
         return;
      end
      if (user_rd_pulse != '0) n_pulse++;
      if (!axi_arready) ready_leak = 1;
   endtask

   logic [1:0]  resp, rresp;
   int          lat, rlat, np, rnp;
   logic [7:0]  pc, rpc;
   bit          leak, rleak, rdy_after;
   logic [31:0] rdat, rdat_end, wdat;
   logic [3:0]  strb;
   int unsigned idx, sel;
   logic [1:0]  exp_resp;
   logic [31:0] exp_data;
   logic [7:0]  exp_pulse;
   int          exp_np;

   initial begin
      axi_rst = 1; axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 0;
      axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0; axi_bready = 0;
      axi_araddr = '0; axi_arprot = '0; axi_arvalid = 0; axi_rready = 0;
      for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
      for (int j = 0; j < NRO; j++) m_ro[j] = $urandom;
      drive_ro();
      repeat (3) @(negedge axi_clk);

      // Reset state
      check("rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b000);
      check("rst_valids", {axi_bvalid, axi_rvalid}, 2'b00);
      check("rst_resp_rdata", {axi_bresp, axi_rresp, axi_rdata}, 36'h0);
      check("rst_pulses", {user_wr_pulse, user_rd_pulse}, 16'h0);
      check("rst_rw_all", user_rw_data == rw_vec(), 1);
      axi_rst = 0;
      @(negedge axi_clk);
      check("post_rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);

      // Same-cycle AW/W full write to index 2
      axi_write(16'd8, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
      m_rw[2] = 32'hDEADBEEF;
      check("w1_resp", resp, 2'b00);
      check("w1_latency", lat, 1);
      check("w1_reg2", user_rw_data[2*32 +: 32], 32'hDEADBEEF);
      check("w1_pulse_at_commit", pc, 8'h04);
      check("w1_pulse_count", np, 1);
      check("w1_readies_after", rdy_after, 1);

      // Partial strobe merge
      axi_write(16'd8, 32'h11223344, 4'b0101, 3'b000, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
      m_rw[2] = 32'hDE22BE44;
      check("w2_resp", resp, 2'b00);
      check("w2_reg2", user_rw_data[2*32 +: 32], 32'hDE22BE44);

      // W three cycles ahead of AW, bready held low four cycles
      axi_write(16'd20, 32'hA5A5_0F0F, 4'hF, 3'b000, 3, 0, 4, resp, lat, pc, np, leak, rdy_after);
      m_rw[5] = 32'hA5A5_0F0F;
      check("w3_resp", resp, 2'b00);
      check("w3_ready_leak", leak, 0);
      check("w3_single_commit", np, 1);
      check("w3_readies_after", rdy_after, 1);
      check("w3_rw_all", user_rw_data == rw_vec(), 1);

      // Zero-strobe write: OKAY, no pulse, no change
      axi_write(16'd4, 32'hFFFF_FFFF, 4'h0, 3'b000, 1, 0, 1, resp, lat, pc, np, leak, rdy_after);
      check("w0strb_resp", resp, 2'b00);
      check("w0strb_pulses", np, 0);
      check("w0strb_rw_all", user_rw_data == rw_vec(), 1);

      // RO register read and miss read
      m_ro[1] = 32'hCAFE0001; drive_ro();
      axi_read(16'((ROB + 1) * 4), 3'b000, 0, 2, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("r_ro1_data", rdat, 32'hCAFE0001);
      check("r_ro1_data_held", rdat_end, 32'hCAFE0001);
      check("r_ro1_resp", rresp, 2'b00);
      check("r_ro1_latency", rlat, 1);
      check("r_ro1_pulse", rpc, 8'h02);
      check("r_ro1_pulse_count", rnp, 1);
      check("r_ro1_arready_leak", rleak, 0);
      axi_read(16'(40 * 4), 3'b000, 0, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("r_miss_data", rdat, 32'h0);
      check("r_miss_resp", rresp, 2'b10);
      check("r_miss_pulses", rnp, 0);

      // Write to an RO register
      axi_write(16'(ROB * 4), 32'h1234_5678, 4'hF, 3'b000, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
      check("w_ro_resp", resp, 2'b10);
      check("w_ro_pulses", np, 0);
      check("w_ro_rw_all", user_rw_data == rw_vec(), 1);

      // Protection handling
`ifdef AXI_REGFILE_PROT_CHECK_EN
      axi_write(16'd0, 32'h7777_7777, 4'hF, 3'b001, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
      check("w_prot_resp", resp, 2'b10);
      check("w_prot_pulses", np, 0);
      check("w_prot_rw_all", user_rw_data == rw_vec(), 1);
      axi_read(16'd8, 3'b001, 0, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("r_prot_data", rdat, 32'h0);
      check("r_prot_resp", rresp, 2'b10);
      axi_read(16'((ROB + 1) * 4), 3'b010, 0, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("r_prot_ro_pulses", rnp, 0);
`else
      axi_write(16'd0, 32'h7777_7777, 4'hF, 3'b001, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
      m_rw[0] = 32'h7777_7777;
      check("w_prot_ignored_resp", resp, 2'b00);
      check("w_prot_ignored_rw_all", user_rw_data == rw_vec(), 1);
      axi_read(16'd8, 3'b001, 0, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("r_prot_ignored_data", rdat, m_rw[2]);
      check("r_prot_ignored_resp", rresp, 2'b00);
`endif

      // Commit and AR on the same edge to the same register: old value returned
      fork
         axi_write(16'd12, 32'h0BAD_F00D, 4'hF, 3'b000, 0, 0, 0, resp, lat, pc, np, leak, rdy_after);
         axi_read(16'd12, 3'b000, 1, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      join
      check("coll_rdata_old", rdat, m_rw[3]);
      m_rw[3] = 32'h0BAD_F00D;
      check("coll_reg3_new", user_rw_data[3*32 +: 32], 32'h0BAD_F00D);

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      idx = $urandom_range(0, NRW - 1);
         else if (sel < 8) idx = ROB + $urandom_range(0, NRO - 1);
         else if (sel < 9) idx = $urandom_range(NRW, ROB - 1);
         else              idx = $urandom_range(ROB + NRO, 16383);
         if ($urandom_range(0, 1) == 0) begin
            wdat = $urandom; strb = 4'($urandom_range(0, 15));
            exp_resp = 2'b10; exp_pulse = '0; exp_np = 0;
            if (idx < NRW) begin
               exp_resp = 2'b00;
               for (int b = 0; b < 4; b++) if (strb[b]) m_rw[idx][b*8 +: 8] = wdat[b*8 +: 8];
               if (strb != 0) begin exp_pulse = 8'(1 << idx); exp_np = 1; end
            end
            axi_write(16'(idx * 4 + $urandom_range(0, 3)), wdat, strb, 3'b000,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      resp, lat, pc, np, leak, rdy_after);
            check("rnd_w_resp", resp, exp_resp);
            check("rnd_w_latency", lat, 1);
            check("rnd_w_pulse", pc, exp_pulse);
            check("rnd_w_pulse_count", np, exp_np);
            check("rnd_w_ready_leak", leak, 0);
            check("rnd_w_rw_all", user_rw_data == rw_vec(), 1);
         end else begin
            exp_resp = 2'b10; exp_data = '0; exp_pulse = '0; exp_np = 0;
            if (idx < NRW) begin
               exp_resp = 2'b00; exp_data = m_rw[idx];
            end else if (idx >= ROB && idx < ROB + NRO) begin
               m_ro[idx - ROB] = $urandom; drive_ro();
               exp_resp = 2'b00; exp_data = m_ro[idx - ROB];
               exp_pulse = 8'(1 << (idx - ROB)); exp_np = 1;
            end
            axi_read(16'(idx * 4 + $urandom_range(0, 3)), 3'b000,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
            check("rnd_r_data", rdat, exp_data);
            check("rnd_r_data_held", rdat_end, exp_data);
            check("rnd_r_resp", rresp, exp_resp);
            check("rnd_r_latency", rlat, 1);
            check("rnd_r_pulse", rpc, exp_pulse);
            check("rnd_r_pulse_count", rnp, exp_np);
            check("rnd_r_ready_leak", rleak, 0);
         end
      end

      // Reset while a write response is pending
      axi_awaddr = 16'd24; axi_awprot = '0; axi_wdata = 32'h5A5A_5A5A; axi_wstrb = 4'hF;
      axi_awvalid = 1; axi_wvalid = 1;
      @(posedge axi_clk); @(negedge axi_clk);
      axi_awvalid = 0; axi_wvalid = 0;
      @(posedge axi_clk); @(negedge axi_clk);
      check("mid_rst_bvalid_before", axi_bvalid, 1);
      check("mid_rst_reg6_before", user_rw_data[6*32 +: 32], 32'h5A5A_5A5A);
      axi_rst = 1;
      @(posedge axi_clk); @(negedge axi_clk);
      for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
      check("mid_rst_bvalid", axi_bvalid, 0);
      check("mid_rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b000);
      check("mid_rst_rw_all", user_rw_data == rw_vec(), 1);
      axi_rst = 0;
      @(posedge axi_clk); @(negedge axi_clk);
      check("mid_rst_readies_back", {axi_awready, axi_wready, axi_arready}, 3'b111);
      axi_read(16'd8, 3'b000, 0, 0, rdat, rdat_end, rresp, rlat, rpc, rnp, rleak);
      check("mid_rst_reg2_read", rdat, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
